regfile_dump_ctrl: RTL and testbench
====================================

REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 Parameter LEN, default 32: register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NB_REG, default 32: number of registers dumped.
REQ-003 Parameter NB_ADDR, default 5: register address width.
REQ-004 i_clk  in  1: clock; all state SHALL update on posedge i_clk.
REQ-005 i_rst  in  1: reset, synchronous, active-low.
REQ-006 i_start  in  1: dump request, sampled in IDLE only.
REQ-007 i_halted  in  1: pipeline halted; qualifies i_start.
REQ-008 o_rf_addr  out  NB_ADDR: register address driven to the register file's combinational read port.
REQ-009 i_rf_data  in  LEN: combinational read data for o_rf_addr.
REQ-010 o_tx_data  out  8: byte to UART transmitter.
REQ-011 o_tx_valid  out  1: o_tx_data valid.
REQ-012 i_tx_ready  in  1: transmitter accepts the byte this cycle.
REQ-013 o_busy  out  1: dump in progress; pipeline write-enable held off while high.
REQ-014 o_done  out  1: one-cycle pulse at dump completion.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SEND, DONE; all outputs registered or decoded from registered state only.
REQ-016 IDLE: i_start=1 and i_halted=1 -> LOAD with word counter 0; i_start with i_halted=0 SHALL be ignored.
REQ-017 o_rf_addr SHALL equal the word counter at all times; 0 in IDLE.
REQ-018 LOAD (1 cycle): capture i_rf_data into a LEN-bit shift register, byte counter := 0, -> SEND.
REQ-019 SEND: o_tx_valid=1, o_tx_data = shift register bits [7:0] (LSB byte first).
REQ-020 o_tx_data SHALL stay stable while o_tx_valid=1 and i_tx_ready=0; o_tx_valid SHALL never drop without a transfer.
REQ-021 Transfer occurs on o_tx_valid=1 and i_tx_ready=1: shift register >>= 8, byte counter += 1.
REQ-022 Transfer of byte LEN/8-1: word counter = NB_REG-1 -> DONE; else word counter += 1 -> LOAD.
REQ-023 o_tx_valid SHALL be 0 in IDLE, LOAD, DONE.
REQ-024 DONE (1 cycle): o_done=1, word counter := 0, -> IDLE.
REQ-025 o_busy SHALL be 1 in LOAD, SEND, DONE; 0 in IDLE.
REQ-026 i_start during LOAD/SEND/DONE SHALL be ignored and not queued.
REQ-027 i_halted is sampled only at start; its deassertion mid-dump SHALL not alter the sequence.
REQ-028 Word counter SHALL not wrap; no address >= NB_REG is ever driven.
REQ-029 With i_tx_ready held 1: LOAD for word k in cycle T+1+5k (T = cycle start sampled), o_done in cycle T+161 (defaults); total NB_REG*LEN/8 bytes.

Reset
REQ-030 i_rst=0 at posedge: state IDLE, word/byte counters 0, shift register 0, o_rf_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
REQ-031 Reset mid-dump SHALL abort immediately; no o_done pulse; no further bytes emitted.
REQ-032 i_start coincident with i_rst=0 SHALL be ignored.

Verification
REQ-033 Regs preloaded r[n]=n, i_halted=1, i_tx_ready=1, 1-cycle i_start -> 128 bytes: 00 00 00 00, 01 00 00 00, ... 1F 00 00 00; o_done in cycle T+161.
REQ-034 r5=0xDEADBEEF, i_tx_ready toggling 1-of-3 cycles -> word 5 bytes EF BE AD DE; o_tx_data stable while stalled; no lost/duplicated byte.
REQ-035 i_start with i_halted=0 -> o_busy stays 0, o_tx_valid stays 0 for 200 cycles.
REQ-036 Second i_start pulse during dump word 10 -> exactly 128 bytes and one o_done.
REQ-037 i_rst=0 during SEND of word 7 byte 2 -> next cycle IDLE, all outputs 0, no o_done; fresh i_start -> complete dump from word 0.
REQ-038 i_tx_ready held 0 for 50 cycles in SEND of word 0 -> o_tx_valid=1, o_tx_data=0x00, o_rf_addr=0 throughout.

Source files
------------

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: streams every register of a halted pipeline out as LSB-first bytes to a UART transmitter
module regfile_dump_ctrl #(
    parameter int LEN     = 32,
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_halted,
    output logic [NB_ADDR-1:0] o_rf_addr,
    input  logic [LEN-1:0]     i_rf_data,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);
    localparam int NBYTE = LEN / 8;
    localparam int BW    = (NBYTE > 1) ? $clog2(NBYTE) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] word_q, word_d;
    logic [BW-1:0]      byte_q, byte_d;
    logic [LEN-1:0]     shift_q, shift_d;

    // Next-state: load a word, shift it out a byte per handshake, advance until the last register is sent
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (i_start && i_halted) begin
                state_d = LOAD;
                word_d  = '0;
            end
            LOAD: begin
                shift_d = i_rf_data;
                byte_d  = '0;
                state_d = SEND;
            end
            SEND: if (i_tx_ready) begin
                shift_d = shift_q >> 8;
                byte_d  = byte_q + 1'b1;
                if (byte_q == BW'(NBYTE - 1)) begin
                    if (word_q == NB_ADDR'(NB_REG - 1)) begin
                        state_d = DONE;
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                word_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset that aborts any dump in progress
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            byte_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
        end
    end

    assign o_rf_addr  = word_q;
    assign o_tx_data  = shift_q[7:0];
    assign o_tx_valid = (state_q == SEND);
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: scoreboard bench for the register-file byte dumper
module tb_regfile_dump_ctrl;
    localparam int LEN     = 32;
    localparam int NB_REG  = 32;
    localparam int NB_ADDR = 5;
    localparam int NBYTES  = NB_REG * LEN / 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               halted = 1'b0;
    logic               ready = 1'b0;
    logic [NB_ADDR-1:0] rf_addr;
    logic [LEN-1:0]     rf_data;
    logic [7:0]         tx_data;
    logic               tx_valid, busy, done;
    logic [LEN-1:0]     rf [NB_REG];

    int errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = 0, pops = 0;
    int ready_mode = 0, t_start = 0;
    logic [7:0] q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    regfile_dump_ctrl #(.LEN(LEN), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_halted(halted),
        .o_rf_addr(rf_addr), .i_rf_data(rf_data),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(ready),
        .o_busy(busy), .o_done(done)
    );

    assign rf_data = rf[rf_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected byte stream: every register in address order, least significant byte first
    task automatic push_dump();
        for (int w = 0; w < NB_REG; w++)
            for (int b = 0; b < LEN / 8; b++)
                q.push_back(8'((rf[w] >> (8 * b)) & 'hFF));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        t_start = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d;
        bit got;
        d = done_cnt;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            got = (done_cnt != d);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_addr"}, rf_addr, 0);
        chk({name, "_data"}, tx_data, 0);
        chk({name, "_valid"}, tx_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
    endtask

    // Cycle counter and ready pattern, changed just after each rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        case (ready_mode)
            0: ready = 1'b1;
            1: ready = (cyc % 3 == 0);
            2: ready = 1'b0;
            default: ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard on every handshake the next edge will commit
    initial forever begin
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, prev_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tx_valid && ready && rst) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_byte: got %0h expected no byte (cycle %0d)", tx_data, cyc);
            end else begin
                chk("byte", tx_data, q.pop_front());
                pops++;
            end
        end
        prev_stall = tx_valid && !ready && rst;
        prev_data  = tx_data;
    end

    initial begin
        int d0, bad;
        bit hit;
        for (int n = 0; n < NB_REG; n++) rf[n] = LEN'(n);
        // Reset with a coincident start request that must be ignored
        halted = 1'b1;
        start  = 1'b1;
        repeat (3) step();
        chk_idle("reset");
        start = 1'b0;
        rst   = 1'b1;
        step();
        chk("start_in_reset_busy", busy, 0);

        // Ascending pattern, ready always high, exact completion timing
        ready_mode = 0;
        pops = 0;
        push_dump();
        pulse_start();
        wait_done(400);
        chk("done_cycle", done_cyc, t_start + 161);
        chk("bytes_plain", pops, NBYTES);
        chk_idle("after_dump");

        // Random words with 0xDEADBEEF at r5, ready asserted one cycle in three
        for (int n = 0; n < NB_REG; n++) rf[n] = LEN'($urandom);
        rf[5] = 32'hDEADBEEF;
        ready_mode = 1;
        pops = 0;
        push_dump();
        pulse_start();
        wait_done(1500);
        chk("bytes_stalled", pops, NBYTES);

        // Start without halt is ignored for 200 cycles
        ready_mode = 0;
        halted = 1'b0;
        d0 = done_cnt;
        pulse_start();
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy || tx_valid) bad++;
        end
        chk("unhalted_activity", bad, 0);
        chk("unhalted_done", done_cnt - d0, 0);
        step();

        // Second start during word 10 with random ready must not queue a second dump
        halted = 1'b1;
        ready_mode = 3;
        for (int n = 0; n < NB_REG; n++) rf[n] = LEN'($urandom);
        pops = 0;
        d0 = done_cnt;
        push_dump();
        pulse_start();
        halted = 1'b0;
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            step();
            hit = (rf_addr == 10 && busy);
        end
        chk("reach_word10", hit, 1);
        halted = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1000);
        repeat (20) step();
        chk("restart_bytes", pops, NBYTES);
        chk("restart_dones", done_cnt - d0, 1);
        chk("restart_busy", busy, 0);

        // Reset during word 7 byte 2 aborts without a done pulse
        ready_mode = 0;
        for (int n = 0; n < NB_REG; n++) rf[n] = LEN'($urandom);
        pops = 0;
        push_dump();
        pulse_start();
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            hit = (pops == 7 * 4 + 2 && tx_valid);
            if (!hit) step();
        end
        chk("reach_w7b2", hit, 1);
        chk("w7_addr", rf_addr, 7);
        d0 = done_cnt;
        rst = 1'b0;
        step();
        chk_idle("abort");
        q.delete();
        rst = 1'b1;
        repeat (20) step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_busy", busy, 0);
        pops = 0;
        push_dump();
        pulse_start();
        wait_done(400);
        chk("fresh_bytes", pops, NBYTES);

        // Ready held low 50 cycles while word 0 byte 0 is presented
        for (int n = 0; n < NB_REG; n++) rf[n] = LEN'(n);
        ready_mode = 2;
        step();
        pops = 0;
        push_dump();
        pulse_start();
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step();
            hit = tx_valid;
        end
        chk("held_reach_send", hit, 1);
        repeat (50) begin
            @(negedge clk);
            chk("held_valid", tx_valid, 1);
            chk("held_data", tx_data, rf[0][7:0]);
            chk("held_addr", rf_addr, 0);
        end
        step();
        ready_mode = 0;
        wait_done(400);
        chk("held_bytes", pops, NBYTES);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
